// File: rtl/blitter_pkg.sv
// blitter_pkg: shared types and default constants for the sprite blitter.
package blitter_pkg;
   localparam int BLIT_CW = 10;
   localparam int BLIT_PIX_W = 16;
   localparam int SHEET_W_DEF = 640;
   localparam int RD_LAT_DEF = 2;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} blit_state_t;
   typedef struct packed {
      logic [BLIT_CW-1:0] x;
      logic [BLIT_CW-1:0] y;
      logic [BLIT_PIX_W-1:0] pix;
      logic skip;
   } blit_entry_t;
endpackage

// File: rtl/blit_fifo.sv
// blit_fifo: return-data FIFO holding tagged pixels between the SRAM and the frame buffer.
module blit_fifo
   import blitter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic push_i,
   input  blit_entry_t din_i,
   input  logic pop_i,
   output blit_entry_t dout_o,
   output logic empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   blit_entry_t mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q;
   assign dout_o = mem_q[rd_q];
   assign empty_o = count_q == '0;
   assign count_o = count_q;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
      end else begin
         wr_q <= push_i ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
         rd_q <= pop_i ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end
   always_ff @(posedge Clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/sprite_blitter_p.sv
// sprite_blitter_p: pipelined sprite copy from SRAM sheet to frame buffer with
// flip, colour-key transparency, fixed read latency and write backpressure.
module sprite_blitter_p
   import blitter_pkg::*;
#(
   parameter int CW = BLIT_CW,
   parameter int PIX_W = BLIT_PIX_W,
   parameter int SRAM_AW = 20,
   parameter int SHEET_W = SHEET_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF,
   parameter int FIFO_DEPTH = RD_LAT + 2
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Draw_Start,
   input  logic [CW-1:0] AddrX_Start,
   input  logic [CW-1:0] AddrY_Start,
   input  logic [CW-1:0] AddrX_Stop,
   input  logic [CW-1:0] AddrY_Stop,
   input  logic [CW-1:0] SRAM_ADDR_X_Start,
   input  logic [CW-1:0] SRAM_ADDR_Y_Start,
   input  logic Flip_X,
   input  logic Transp_En,
   input  logic [PIX_W-1:0] Color_Key,
   output logic SRAM_Rd,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   input  logic [PIX_W-1:0] Data_Read,
   output logic [CW-1:0] AddrX,
   output logic [CW-1:0] AddrY,
   output logic [PIX_W-1:0] ColorIdxOut,
   output logic We,
   input  logic Fb_Ready,
   output logic Busy,
   output logic Draw_Done
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   blit_state_t state_q;
   logic [CW-1:0] x0_q, y0_q, w_q, h_q, sx_q, sy_q, dx_q, dy_q;
   logic flip_q, transp_q;
   logic [PIX_W-1:0] key_q;
   logic [CNT_W-1:0] in_flight_q, fifo_cnt;
   logic [RD_LAT-1:0] vld_q;
   logic [CW-1:0] tx_q [RD_LAT];
   logic [CW-1:0] ty_q [RD_LAT];
   logic [CW-1:0] src_x, src_y;
   logic last_px, row_end, arrive, fifo_empty, fifo_pop;
   blit_entry_t head, push_entry;
   assign src_x = sx_q + (flip_q ? w_q - CW'(1) - dx_q : dx_q);
   assign src_y = sy_q + dy_q;
   assign row_end = dx_q == w_q - CW'(1);
   assign last_px = row_end && dy_q == h_q - CW'(1);
   // Credit counts reads in the tag pipe plus FIFO entries, so a full stall can never overflow the FIFO.
   assign SRAM_Rd = state_q == ISSUE && {1'b0, in_flight_q} + {1'b0, fifo_cnt} < (CNT_W + 1)'(FIFO_DEPTH);
   assign SRAM_ADDR = SRAM_Rd ? SRAM_AW'(src_y) * SRAM_AW'(SHEET_W) + SRAM_AW'(src_x) : '0;
   assign arrive = vld_q[RD_LAT-1];
   assign push_entry = '{x: tx_q[RD_LAT-1], y: ty_q[RD_LAT-1], pix: Data_Read,
                         skip: transp_q && Data_Read == key_q};
   assign We = !fifo_empty && !head.skip;
   assign fifo_pop = !fifo_empty && (head.skip || Fb_Ready);
   assign AddrX = We ? head.x : '0;
   assign AddrY = We ? head.y : '0;
   assign ColorIdxOut = We ? head.pix : '0;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         {x0_q, y0_q, w_q, h_q, sx_q, sy_q, dx_q, dy_q} <= '0;
         {flip_q, transp_q, key_q} <= '0;
         Busy <= 1'b0;
         Draw_Done <= 1'b0;
      end else begin
         Draw_Done <= 1'b0;
         case (state_q)
            IDLE: if (Draw_Start) begin
               x0_q <= AddrX_Start;
               y0_q <= AddrY_Start;
               w_q <= AddrX_Stop - AddrX_Start;
               h_q <= AddrY_Stop - AddrY_Start;
               sx_q <= SRAM_ADDR_X_Start;
               sy_q <= SRAM_ADDR_Y_Start;
               flip_q <= Flip_X;
               transp_q <= Transp_En;
               key_q <= Color_Key;
               dx_q <= '0;
               dy_q <= '0;
               if (AddrX_Stop <= AddrX_Start || AddrY_Stop <= AddrY_Start) state_q <= DONE;
               else begin
                  state_q <= ISSUE;
                  Busy <= 1'b1;
               end
            end
            ISSUE: if (SRAM_Rd) begin
               dx_q <= row_end ? '0 : dx_q + CW'(1);
               dy_q <= row_end ? dy_q + CW'(1) : dy_q;
               if (last_px) state_q <= DRAIN;
            end
            DRAIN: if (in_flight_q == '0 && fifo_empty) begin
               state_q <= DONE;
               Busy <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               Draw_Done <= 1'b1;
            end
         endcase
      end
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vld_q <= '0;
         in_flight_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tx_q[i] <= '0;
            ty_q[i] <= '0;
         end
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_q[i] <= vld_q[i-1];
            tx_q[i] <= tx_q[i-1];
            ty_q[i] <= ty_q[i-1];
         end
         vld_q[0] <= SRAM_Rd;
         tx_q[0] <= x0_q + dx_q;
         ty_q[0] <= y0_q + dy_q;
         in_flight_q <= in_flight_q + CNT_W'(SRAM_Rd) - CNT_W'(arrive);
      end
   end
   blit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .push_i(arrive),
      .din_i(push_entry),
      .pop_i(fifo_pop),
      .dout_o(head),
      .empty_o(fifo_empty),
      .count_o(fifo_cnt)
   );
endmodule

// File: tb/tb_sprite_blitter_p.sv
// tb_sprite_blitter_p: directed and random sprite copies checked against a raster-order queue model.
module tb_sprite_blitter_p;
   localparam int RD_LAT = 2;
   localparam int DEPTH = RD_LAT + 2;
   logic clk = 0, Reset_n = 0, Draw_Start = 0, Flip_X = 0, Transp_En = 0, Fb_Ready = 1;
   logic [9:0] AddrX_Start = 0, AddrY_Start = 0, AddrX_Stop = 0, AddrY_Stop = 0;
   logic [9:0] SRAM_ADDR_X_Start = 0, SRAM_ADDR_Y_Start = 0;
   logic [15:0] Color_Key = 0, Data_Read = 0;
   logic SRAM_Rd, We, Busy, Draw_Done;
   logic [19:0] SRAM_ADDR;
   logic [9:0] AddrX, AddrY;
   logic [15:0] ColorIdxOut;
   int checks = 0, failures = 0;
   int rd_cnt = 0, wr_cnt = 0, max_out = 0;
   bit small_mode = 0;
   logic [63:0] exp_rd [$];
   logic [63:0] exp_wr [$];
   logic rv [RD_LAT+1] = '{default: 1'b0};
   logic [19:0] ra [RD_LAT+1] = '{default: 20'd0};

   sprite_blitter_p dut (
      .Clk(clk), .Reset_n(Reset_n), .Draw_Start(Draw_Start),
      .AddrX_Start(AddrX_Start), .AddrY_Start(AddrY_Start),
      .AddrX_Stop(AddrX_Stop), .AddrY_Stop(AddrY_Stop),
      .SRAM_ADDR_X_Start(SRAM_ADDR_X_Start), .SRAM_ADDR_Y_Start(SRAM_ADDR_Y_Start),
      .Flip_X(Flip_X), .Transp_En(Transp_En), .Color_Key(Color_Key),
      .SRAM_Rd(SRAM_Rd), .SRAM_ADDR(SRAM_ADDR), .Data_Read(Data_Read),
      .AddrX(AddrX), .AddrY(AddrY), .ColorIdxOut(ColorIdxOut), .We(We),
      .Fb_Ready(Fb_Ready), .Busy(Busy), .Draw_Done(Draw_Done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_model(input logic [19:0] a);
      return small_mode ? (a[0] ? 16'd5 : 16'd0) : 16'((32'(a) * 32'd40503) >> 5);
   endfunction

   // SRAM model and write/read scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (Reset_n) begin
         if (SRAM_Rd) begin
            rd_cnt++;
            if (exp_rd.size() == 0) chk("rd_extra", 64'(SRAM_ADDR), '1);
            else chk("rd_addr", 64'(SRAM_ADDR), exp_rd.pop_front());
         end
         if (rd_cnt - wr_cnt > max_out) max_out = rd_cnt - wr_cnt;
         if (We && Fb_Ready) begin
            wr_cnt++;
            if (exp_wr.size() == 0) chk("wr_extra", {28'd0, AddrX, AddrY, ColorIdxOut}, '1);
            else chk("wr", {28'd0, AddrX, AddrY, ColorIdxOut}, exp_wr.pop_front());
         end
      end
      for (int i = RD_LAT; i > 0; i--) begin
         rv[i] = rv[i-1];
         ra[i] = ra[i-1];
      end
      rv[0] = SRAM_Rd;
      ra[0] = SRAM_ADDR;
      Data_Read = rv[RD_LAT] ? mem_model(ra[RD_LAT]) : 16'($urandom);
   end

   task automatic run_op(input string tag, input int x0, y0, w, h, sx, sy,
                         input bit flip, tr, sm, input logic [15:0] key, input int bp, inj);
      int lat, first_we, bad;
      bit nz;
      nz = w > 0 && h > 0;
      exp_rd.delete();
      exp_wr.delete();
      rd_cnt = 0;
      wr_cnt = 0;
      max_out = 0;
      small_mode = sm;
      if (nz) for (int dy = 0; dy < h; dy++) for (int dx = 0; dx < w; dx++) begin
         logic [9:0] px, py;
         logic [19:0] a;
         logic [15:0] d;
         px = 10'(sx + (flip ? w - 1 - dx : dx));
         py = 10'(sy + dy);
         a = 20'(int'(py) * 640 + int'(px));
         exp_rd.push_back(64'(a));
         d = mem_model(a);
         if (!(tr && d == key)) exp_wr.push_back({28'd0, 10'(x0 + dx), 10'(y0 + dy), d});
      end
      @(posedge clk); #1;
      AddrX_Start = 10'(x0); AddrX_Stop = 10'(x0 + w);
      AddrY_Start = 10'(y0); AddrY_Stop = 10'(y0 + h);
      SRAM_ADDR_X_Start = 10'(sx); SRAM_ADDR_Y_Start = 10'(sy);
      Flip_X = flip; Transp_En = tr; Color_Key = key;
      Fb_Ready = 1'b1;
      Draw_Start = 1'b1;
      lat = 0;
      first_we = 0;
      for (int k = 1; k <= 4000 && lat == 0; k++) begin
         @(posedge clk); #1;
         Draw_Start = inj == 1 && (k == 3 || k == 4);
         if (Draw_Start) begin
            AddrX_Start = 10'($urandom);
            Flip_X = ~Flip_X;
         end
         Fb_Ready = bp == 0 ? 1'b1 : bp == 1 ? 1'($urandom) : !(k >= 5 && k <= 15);
         if (k == 1) chk({tag, "_busy"}, 64'(Busy), 64'(nz));
         if (inj == 2 && k == 6) begin
            Reset_n = 1'b0;
            #1;
            chk("rst_out", {SRAM_Rd, SRAM_ADDR, AddrX, AddrY, ColorIdxOut, We, Busy, Draw_Done}, 64'd0);
            exp_rd.delete();
            exp_wr.delete();
            @(posedge clk); #1;
            Reset_n = 1'b1;
            bad = 0;
            repeat (8) begin
               @(posedge clk); #1;
               bad += int'(We) + int'(Draw_Done) + int'(Busy) + int'(SRAM_Rd);
            end
            chk("rst_quiet", 64'(bad), 64'd0);
            return;
         end
         if (We && first_we == 0) first_we = k;
         if (Draw_Done) lat = k;
      end
      chk({tag, "_done"}, 64'(lat != 0), 64'd1);
      if (bp == 0) chk({tag, "_lat"}, 64'(lat), 64'(nz ? w * h + RD_LAT + 4 : 2));
      if (bp == 0 && nz && !tr) chk({tag, "_first_we"}, 64'(first_we), 64'(RD_LAT + 2));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 64'(Draw_Done), 64'd0);
      chk({tag, "_idle"}, 64'(Busy), 64'd0);
      chk({tag, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
      chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", {SRAM_Rd, SRAM_ADDR, AddrX, AddrY, ColorIdxOut, We, Busy, Draw_Done}, 64'd0);
      Reset_n = 1'b1;
      run_op("basic", 0, 0, 20, 10, 300, 400, 0, 0, 0, 16'h0, 0, 0);
      chk("basic_writes", 64'(wr_cnt), 64'd200);
      run_op("flip", 0, 0, 4, 1, 300, 400, 1, 0, 0, 16'h0, 0, 0);
      run_op("transp", 0, 0, 4, 1, 300, 400, 0, 1, 1, 16'h0, 0, 0);
      chk("transp_writes", 64'(wr_cnt), 64'd2);
      run_op("bp", 0, 0, 20, 10, 300, 400, 0, 0, 0, 16'h0, 2, 0);
      chk("bp_outstanding", 64'(max_out), 64'(DEPTH));
      chk("bp_writes", 64'(wr_cnt), 64'd200);
      run_op("zero", 5, 5, 0, 3, 10, 10, 0, 0, 0, 16'h0, 0, 0);
      chk("zero_reads", 64'(rd_cnt), 64'd0);
      run_op("ignore", 10, 20, 6, 3, 50, 60, 0, 0, 0, 16'h0, 0, 1);
      run_op("reset", 0, 0, 20, 10, 300, 400, 0, 0, 0, 16'h0, 0, 2);
      run_op("post", 0, 0, 20, 10, 300, 400, 0, 0, 0, 16'h0, 0, 0);
      for (int n = 0; n < 24; n++) begin
         bit sm;
         sm = 1'($urandom);
         run_op("rand", $urandom_range(0, 1000), $urandom_range(0, 1000), $urandom_range(0, 12),
                $urandom_range(0, 5), $urandom_range(0, 1023), $urandom_range(0, 1000),
                1'($urandom), 1'($urandom), sm, sm ? 16'($urandom_range(0, 1) * 5) : 16'($urandom),
                $urandom_range(0, 1), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
